mwr_tlp_sender: RTL and testbench
=================================

# mwr_tlp_sender

Pops memory-write TLP headers from the AW header FIFO, filled by the AXI AW header stage, and payload beats from the W data FIFO. Emits each complete posted MWr TLP, header beat first and then payload beats, on a 256-bit transmit stream toward the data-link layer. The block sits directly downstream of the AW header FIFO and the W data FIFO. An optional posted flow-control credit gate holds back a TLP until the link partner has advertised enough credit for it.

## Interface
Parameters:
- DATA_WIDTH, 256, payload beat width; fixed, 8 DW per beat
- INIT_PH, 8'd32, posted-header credits available after reset
- INIT_PD, 12'd256, posted-data credits available after reset; 1 credit = 4 DW

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- hdr_fifo_empty  in  1  header FIFO empty; the FIFO is first-word-fall-through
- hdr_fifo_rdata  in  128  head header; valid while !hdr_fifo_empty
- hdr_fifo_rden  out  1  pops one header
- wd_fifo_empty  in  1  W data FIFO empty; the FIFO is first-word-fall-through
- wd_fifo_rdata  in  256  head payload beat
- wd_fifo_rden  out  1  pops one beat
- tlp_valid  out  1  stream beat valid
- tlp_ready  in  1  downstream accepts the beat
- tlp_data  out  256  beat data
- tlp_sop  out  1  first beat of the TLP (header beat)
- tlp_eop  out  1  last beat of the TLP
- fc_upd_valid  in  1  credit return strobe
- fc_ph_inc  in  8  posted-header credits returned
- fc_pd_inc  in  12  posted-data credits returned
- busy  out  1  state != IDLE

## Operation
- Header length field: len = hdr_fifo_rdata[9:0], in DW; len==0 means 1024.
- Beat count: beats = ceil(len/8), computed in 8 bits, range 1..128.
- FSM states: IDLE, HDR, DATA.
- IDLE: go to HDR when !hdr_fifo_empty and the credit gate passes.
- HDR: drive the header beat.
  - tlp_valid=1, tlp_sop=1, tlp_eop=0.
  - tlp_data = {128'd0, hdr_fifo_rdata}.
  - On tlp_valid&&tlp_ready: hdr_fifo_rden=1, the beat counter loads beats, go to DATA.
- DATA: drive payload beats.
  - tlp_valid = !wd_fifo_empty, tlp_data = wd_fifo_rdata, tlp_sop=0.
  - tlp_eop = (cnt==1).
  - On handshake: wd_fifo_rden=1 and cnt decrements.
  - On handshake with cnt==1: go to IDLE.
- FIFO pops are strictly tlp_valid&&tlp_ready in the matching state. No speculative reads are made.
- tlp_data is don't-care when tlp_valid=0; the implementation drives 0 in that case.
- Outputs tlp_valid, tlp_data, tlp_sop, tlp_eop, hdr_fifo_rden and wd_fifo_rden are combinational from the state, the counter and the FIFO outputs.
- Payload underrun (wd_fifo_empty in DATA): hold tlp_valid=0 and wait. A TLP is never truncated and never interleaved with another.
- Backpressure: with tlp_ready=0, every stream output is held stable and no pop occurs.
- Reset: state IDLE, counter 0, credits set to INIT_PH/INIT_PD. Every output is 0. FIFO contents are untouched.
- Reset mid-TLP: the partial TLP is abandoned. Upstream realigns by flushing.

## Timing
- The IDLE->HDR decision takes one cycle. The header beat can be accepted on the cycle after the header appears in the FIFO.
- A back-to-back TLP costs one idle bubble (DATA -> IDLE -> HDR).
- Minimum TLP duration with no stalls: 1 + beats cycles, plus one cycle in IDLE.
- Credit deduction is registered and takes effect on the header-beat handshake cycle.
- A credit update in the same cycle as a deduction is applied as (avail + inc - cost).

## Configuration
- Macro: MWR_CREDIT_CHECK_EN.
- Defined:
  - Keep ph_avail (8-bit) and pd_avail (12-bit), each saturating at its maximum.
  - The IDLE->HDR gate additionally requires ph_avail>=1 and pd_avail>=ceil(len/4).
  - On the header handshake, ph_avail decrements by 1 and pd_avail by ceil(len/4).
  - fc_upd_valid adds fc_ph_inc and fc_pd_inc.
- Undefined:
  - No counters exist and the gate always passes.
  - fc_* ports are present but ignored.

## Test plan
- Single TLP, len=16: header H and 2 beats queued, tlp_ready=1.
  - Expect 3 consecutive beats: H with sop=1, D0, D1 with eop=1.
  - Expect one hdr pop and two wd pops.
- len=0 (1024 DW) with ready toggling randomly: exactly 128 payload beats, eop only on the 128th, data order preserved.
- Payload underrun: header queued with a 4-beat payload, wd FIFO empty for 5 cycles after the header.
  - Expect tlp_valid=0 during the gap and no wd pop.
  - The TLP then completes.
- Two back-to-back TLPs of len=8: sequence H0,D0(eop), then one bubble, then H1,D1(eop). sop and eop are correct on each.
- Credit gating (MWR_CREDIT_CHECK_EN, INIT_PD=2), TLP with len=16, needing 4 credits:
  - It is held in IDLE.
  - After fc_upd_valid with fc_pd_inc=2, it is sent and pd_avail becomes 0.
- Reset asserted mid-DATA (cnt=3): busy=0 and outputs are 0 immediately.
  - After release, the next header is processed from HDR.

Source files
------------

// File: rtl/mwr_tlp_sender.sv
// ============================================================================
// mwr_tlp_sender: drains MWr headers and payload beats into a 256-bit TLP stream
// Optional posted credit gate: MWR_CREDIT_CHECK_EN.  Revision 1.0
// ============================================================================
`default_nettype none

module mwr_tlp_sender #(
  parameter int          DATA_WIDTH = 256,
  parameter logic [7:0]  INIT_PH    = 8'd32,
  parameter logic [11:0] INIT_PD    = 12'd256
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  hdr_fifo_empty,
  input  logic [127:0]          hdr_fifo_rdata,
  output logic                  hdr_fifo_rden,
  input  logic                  wd_fifo_empty,
  input  logic [DATA_WIDTH-1:0] wd_fifo_rdata,
  output logic                  wd_fifo_rden,
  output logic                  tlp_valid,
  input  logic                  tlp_ready,
  output logic [DATA_WIDTH-1:0] tlp_data,
  output logic                  tlp_sop,
  output logic                  tlp_eop,
  input  logic                  fc_upd_valid,
  input  logic [7:0]            fc_ph_inc,
  input  logic [11:0]           fc_pd_inc,
  output logic                  busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    DATA = 2'd2
  } state_t;

  state_t     state, state_nxt;
  logic [7:0] cnt, cnt_nxt;

  logic [10:0] len_dw;
  logic [7:0]  beats;
  logic        credit_ok;
  logic        hdr_hs;

  // A zero length field encodes the maximum 1024 DW payload.
  assign len_dw = (hdr_fifo_rdata[9:0] == 10'd0) ? 11'd1024 : {1'b0, hdr_fifo_rdata[9:0]};
  assign beats  = len_dw[10:3] + {7'd0, |len_dw[2:0]};
  assign hdr_hs = (state == HDR) && tlp_ready;

`ifdef MWR_CREDIT_CHECK_EN
  logic [7:0]  ph_avail;
  logic [11:0] pd_avail;
  logic [8:0]  pd_cost;
  logic [8:0]  ph_sum;
  logic [12:0] pd_sum;

  assign pd_cost   = len_dw[10:2] + {8'd0, |len_dw[1:0]};
  assign credit_ok = (ph_avail != 8'd0) && (pd_avail >= {3'd0, pd_cost});

  // Returns and the header-beat deduction can coincide; the gate guarantees no underflow.
  assign ph_sum = {1'b0, ph_avail}
                + (fc_upd_valid ? {1'b0, fc_ph_inc} : 9'd0)
                - {8'd0, hdr_hs};
  assign pd_sum = {1'b0, pd_avail}
                + (fc_upd_valid ? {1'b0, fc_pd_inc} : 13'd0)
                - (hdr_hs ? {4'd0, pd_cost} : 13'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ph_avail <= INIT_PH;
      pd_avail <= INIT_PD;
    end else begin
      ph_avail <= ph_sum[8]  ? 8'hFF   : ph_sum[7:0];
      pd_avail <= pd_sum[12] ? 12'hFFF : pd_sum[11:0];
    end
  end
`else
  logic unused_fc;
  assign unused_fc = ^{fc_upd_valid, fc_ph_inc, fc_pd_inc, INIT_PH, INIT_PD};
  assign credit_ok = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= 8'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    tlp_valid     = 1'b0;
    tlp_data      = '0;
    tlp_sop       = 1'b0;
    tlp_eop       = 1'b0;
    hdr_fifo_rden = 1'b0;
    wd_fifo_rden  = 1'b0;
    case (state)
      IDLE: begin
        if (!hdr_fifo_empty && credit_ok)
          state_nxt = HDR;
      end
      HDR: begin
        tlp_valid = 1'b1;
        tlp_sop   = 1'b1;
        tlp_data  = {{(DATA_WIDTH-128){1'b0}}, hdr_fifo_rdata};
        if (tlp_ready) begin
          hdr_fifo_rden = 1'b1;
          cnt_nxt       = beats;
          state_nxt     = DATA;
        end
      end
      DATA: begin
        tlp_valid = !wd_fifo_empty;
        tlp_eop   = !wd_fifo_empty && (cnt == 8'd1);
        if (!wd_fifo_empty) tlp_data = wd_fifo_rdata;
        if (!wd_fifo_empty && tlp_ready) begin
          wd_fifo_rden = 1'b1;
          cnt_nxt      = cnt - 8'd1;
          if (cnt == 8'd1) state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_mwr_tlp_sender.sv
// ============================================================================
// tb_mwr_tlp_sender: directed self-checking bench with behavioural FWFT FIFOs
// ============================================================================
`default_nettype none

module tb_mwr_tlp_sender;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         hdr_fifo_empty;
  logic [127:0] hdr_fifo_rdata;
  logic         hdr_fifo_rden;
  logic         wd_fifo_empty;
  logic [255:0] wd_fifo_rdata;
  logic         wd_fifo_rden;
  logic         tlp_valid;
  logic         tlp_ready;
  logic [255:0] tlp_data;
  logic         tlp_sop;
  logic         tlp_eop;
  logic         fc_upd_valid;
  logic [7:0]   fc_ph_inc;
  logic [11:0]  fc_pd_inc;
  logic         busy;

`ifdef MWR_CREDIT_CHECK_EN
  localparam logic [11:0] TB_INIT_PD = 12'd2;
`else
  localparam logic [11:0] TB_INIT_PD = 12'd256;
`endif

  mwr_tlp_sender #(
    .DATA_WIDTH(256),
    .INIT_PH   (8'd32),
    .INIT_PD   (TB_INIT_PD)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .hdr_fifo_empty(hdr_fifo_empty),
    .hdr_fifo_rdata(hdr_fifo_rdata),
    .hdr_fifo_rden (hdr_fifo_rden),
    .wd_fifo_empty (wd_fifo_empty),
    .wd_fifo_rdata (wd_fifo_rdata),
    .wd_fifo_rden  (wd_fifo_rden),
    .tlp_valid     (tlp_valid),
    .tlp_ready     (tlp_ready),
    .tlp_data      (tlp_data),
    .tlp_sop       (tlp_sop),
    .tlp_eop       (tlp_eop),
    .fc_upd_valid  (fc_upd_valid),
    .fc_ph_inc     (fc_ph_inc),
    .fc_pd_inc     (fc_pd_inc),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         sop;
    logic         eop;
    logic [255:0] data;
    int           cyc;
  } beat_t;

  beat_t        log_q[$];
  logic [127:0] hq[$];
  logic [255:0] wq[$];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int hdr_pops = 0;
  int wd_pops  = 0;
  int unstable = 0;
  int valid_seen = 0;

  logic         prv_hold = 1'b0;
  logic [255:0] prv_data;
  logic         prv_sop, prv_eop;

  function automatic logic [127:0] mk_hdr(input int tag, input int len);
    logic [127:0] h;
    h          = '0;
    h[127:96]  = 32'h4000_0000 | tag;
    h[63:32]   = 32'hDEAD_0000 + tag;
    h[9:0]     = len[9:0];
    return h;
  endfunction

  function automatic logic [255:0] mk_beat(input int tag, input int idx);
    logic [31:0] w;
    w = {tag[15:0], idx[15:0]};
    return {8{w}};
  endfunction

  task automatic refresh();
    hdr_fifo_empty = (hq.size() == 0);
    hdr_fifo_rdata = (hq.size() != 0) ? hq[0] : '0;
    wd_fifo_empty  = (wq.size() == 0);
    wd_fifo_rdata  = (wq.size() != 0) ? wq[0] : '0;
  endtask

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: sample outputs, record handshakes, pop the modelled FIFOs on the edge.
  task automatic tick();
    logic         hr, wr;
    beat_t        b;
    logic [127:0] dh;
    logic [255:0] dw;
    #1;
    hr = hdr_fifo_rden;
    wr = wd_fifo_rden;
    if (tlp_valid) valid_seen++;
    if (prv_hold && (tlp_valid !== 1'b1 || tlp_data !== prv_data ||
                     tlp_sop !== prv_sop || tlp_eop !== prv_eop))
      unstable++;
    prv_hold = tlp_valid && !tlp_ready;
    prv_data = tlp_data;
    prv_sop  = tlp_sop;
    prv_eop  = tlp_eop;
    if (tlp_valid && tlp_ready) begin
      b.sop  = tlp_sop;
      b.eop  = tlp_eop;
      b.data = tlp_data;
      b.cyc  = cyc;
      log_q.push_back(b);
    end
    @(posedge clk);
    if (hr && hq.size() != 0) begin dh = hq.pop_front(); hdr_pops++; end
    if (wr && wq.size() != 0) begin dw = wq.pop_front(); wd_pops++; end
    cyc++;
    #1 refresh();
    #1;
  endtask

  task automatic run_until(input int n, input int budget, input string tag);
    int k = 0;
    while (log_q.size() < n && k < budget) begin
      tick();
      k++;
    end
    chk(tag, log_q.size(), n);
  endtask

  initial begin
    int c0, errs, eops, sops;
    rst_n = 1'b0;
    tlp_ready = 1'b0;
    fc_upd_valid = 1'b0;
    fc_ph_inc = '0;
    fc_pd_inc = '0;
    refresh();
    repeat (3) @(posedge clk);
    #2;
    chk("rst_valid", tlp_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_data", tlp_data, '0);
    chk("rst_sop_eop", {tlp_sop, tlp_eop}, 2'b00);
    chk("rst_rden", {hdr_fifo_rden, wd_fifo_rden}, 2'b00);
    rst_n = 1'b1;
    tick();

`ifdef MWR_CREDIT_CHECK_EN
    // Needs 4 data credits with only 2 available.
    tlp_ready = 1'b1;
    log_q.delete();
    hdr_pops = 0;
    hq.push_back(mk_hdr(8, 16));
    wq.push_back(mk_beat(8, 0));
    wq.push_back(mk_beat(8, 1));
    refresh();
    repeat (6) tick();
    chk("cr_held_log", log_q.size(), 0);
    chk("cr_held_busy", busy, 1'b0);
    chk("cr_held_pops", hdr_pops, 0);
    fc_upd_valid = 1'b1;
    fc_pd_inc = 12'd2;
    tick();
    fc_upd_valid = 1'b0;
    fc_pd_inc = '0;
    run_until(3, 20, "cr_sent");
    chk("cr_pd_avail", dut.pd_avail, 12'd0);
    chk("cr_ph_avail", dut.ph_avail, 8'd31);
    fc_upd_valid = 1'b1;
    fc_pd_inc = 12'hFFF;
    tick();
    fc_upd_valid = 1'b0;
    fc_pd_inc = '0;
    chk("cr_pd_sat", dut.pd_avail, 12'hFFF);
`endif

    // Single TLP, len=16.
    tlp_ready = 1'b1;
    log_q.delete();
    hdr_pops = 0;
    wd_pops = 0;
    hq.push_back(mk_hdr(1, 16));
    wq.push_back(mk_beat(1, 0));
    wq.push_back(mk_beat(1, 1));
    refresh();
    c0 = cyc;
    run_until(3, 20, "t1_done");
    if (log_q.size() >= 3) begin
      chk("t1_h_sopeop", {log_q[0].sop, log_q[0].eop}, 2'b10);
      chk("t1_h_data", log_q[0].data, {128'd0, mk_hdr(1, 16)});
      chk("t1_h_latency", log_q[0].cyc - c0, 1);
      chk("t1_d0_data", log_q[1].data, mk_beat(1, 0));
      chk("t1_d0_sopeop", {log_q[1].sop, log_q[1].eop}, 2'b00);
      chk("t1_d1_data", log_q[2].data, mk_beat(1, 1));
      chk("t1_d1_sopeop", {log_q[2].sop, log_q[2].eop}, 2'b01);
      chk("t1_contig", log_q[2].cyc - log_q[0].cyc, 2);
    end
    chk("t1_hdr_pops", hdr_pops, 1);
    chk("t1_wd_pops", wd_pops, 2);
    tick();
    chk("t1_idle_busy", busy, 1'b0);

    // len=0 (1024 DW) with random backpressure.
    log_q.delete();
    wd_pops = 0;
    unstable = 0;
    hq.push_back(mk_hdr(2, 0));
    for (int i = 0; i < 128; i++) wq.push_back(mk_beat(2, i));
    refresh();
    begin
      int k = 0;
      while (log_q.size() < 129 && k < 3000) begin
        tlp_ready = 1'($urandom_range(0, 1));
        tick();
        k++;
      end
    end
    tlp_ready = 1'b1;
    chk("t2_done", log_q.size(), 129);
    errs = 0;
    eops = 0;
    sops = 0;
    for (int i = 0; i < log_q.size(); i++) begin
      if (log_q[i].eop) eops++;
      if (log_q[i].sop) sops++;
      if (i > 0 && log_q[i].data !== mk_beat(2, i - 1)) errs++;
    end
    chk("t2_order_errs", errs, 0);
    chk("t2_eop_count", eops, 1);
    chk("t2_sop_count", sops, 1);
    if (log_q.size() == 129) begin
      chk("t2_last_eop", log_q[128].eop, 1'b1);
      chk("t2_h_data", log_q[0].data, {128'd0, mk_hdr(2, 0)});
    end
    chk("t2_wd_pops", wd_pops, 128);
    chk("t2_stable", unstable, 0);

    // Payload underrun.
    log_q.delete();
    hq.push_back(mk_hdr(3, 32));
    refresh();
    run_until(1, 10, "t3_hdr");
    wd_pops = 0;
    valid_seen = 0;
    repeat (5) tick();
    chk("t3_gap_valid", valid_seen, 0);
    chk("t3_gap_pops", wd_pops, 0);
    chk("t3_gap_busy", busy, 1'b1);
    for (int i = 0; i < 4; i++) wq.push_back(mk_beat(3, i));
    refresh();
    run_until(5, 20, "t3_done");
    if (log_q.size() >= 5) begin
      chk("t3_d0_data", log_q[1].data, mk_beat(3, 0));
      chk("t3_d3_data", log_q[4].data, mk_beat(3, 3));
      chk("t3_eops", {log_q[1].eop, log_q[2].eop, log_q[3].eop, log_q[4].eop}, 4'b0001);
    end
    chk("t3_wd_pops", wd_pops, 4);

    // Back-to-back len=8 TLPs.
    tick();
    log_q.delete();
    hq.push_back(mk_hdr(4, 8));
    hq.push_back(mk_hdr(5, 8));
    wq.push_back(mk_beat(4, 0));
    wq.push_back(mk_beat(5, 0));
    refresh();
    run_until(4, 20, "t4_done");
    if (log_q.size() >= 4) begin
      chk("t4_sops", {log_q[0].sop, log_q[1].sop, log_q[2].sop, log_q[3].sop}, 4'b1010);
      chk("t4_eops", {log_q[0].eop, log_q[1].eop, log_q[2].eop, log_q[3].eop}, 4'b0101);
      chk("t4_h1_data", log_q[2].data, {128'd0, mk_hdr(5, 8)});
      chk("t4_d1_data", log_q[3].data, mk_beat(5, 0));
      chk("t4_gap01", log_q[1].cyc - log_q[0].cyc, 1);
      chk("t4_bubble", log_q[2].cyc - log_q[1].cyc, 2);
      chk("t4_gap23", log_q[3].cyc - log_q[2].cyc, 1);
    end

    // Reset mid-DATA with three beats outstanding.
    tick();
    log_q.delete();
    hq.push_back(mk_hdr(6, 40));
    for (int i = 0; i < 5; i++) wq.push_back(mk_beat(6, i));
    refresh();
    run_until(3, 20, "t5_pre");
    chk("t5_pre_busy", busy, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    chk("t5_rst_busy", busy, 1'b0);
    chk("t5_rst_valid", tlp_valid, 1'b0);
    chk("t5_rst_data", tlp_data, '0);
    chk("t5_rst_flags", {tlp_sop, tlp_eop, hdr_fifo_rden, wd_fifo_rden}, 4'b0000);
    wq.delete();
    refresh();
    tick();
    rst_n = 1'b1;
    log_q.delete();
    hq.push_back(mk_hdr(7, 8));
    wq.push_back(mk_beat(7, 0));
    refresh();
    c0 = cyc;
    run_until(2, 20, "t5_post");
    if (log_q.size() >= 2) begin
      chk("t5_post_h", log_q[0].data, {128'd0, mk_hdr(7, 8)});
      chk("t5_post_sop", log_q[0].sop, 1'b1);
      chk("t5_post_lat", log_q[0].cyc - c0, 1);
      chk("t5_post_d", {log_q[1].eop, log_q[1].data}, {1'b1, mk_beat(7, 0)});
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
